regfile_access_ctrl: RTL and testbench



---
 rtl/regfile_access_ctrl_if.sv | 58 +++++
 rtl/regfile_access_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_ctrl_if.sv
// Bundle of every requester handshake and register-file port signal used by
// regfile_access_ctrl. The slave modport is the controller's view. The master
// modport is the environment's view: requesters plus the register file.
interface regfile_access_ctrl_if;
    // Writeback requester
    logic        wb_req;
    logic [3:0]  wb_id;
    logic [15:0] wb_data;
    logic        wb_gnt;
    // Stack-pointer adjust requester
    logic        stk_req;
    logic        stk_push;
    logic        stk_pop;
    logic        stk_gnt;
    // Operand fetch requester
    logic        fe_req;
    logic [3:0]  fe_a;
    logic [3:0]  fe_b;
    logic        fe_two;
    logic        fe_gnt;
    logic        fe_done;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    // Register file access port
    logic        rf_rd;
    logic        rf_wn;
    logic [3:0]  rf_reg_id;
    logic [15:0] rf_write_data;
    logic        rf_stack_en;
    logic        rf_push_en;
    logic        rf_pop_en;
    logic [15:0] rf_read_data;

    modport slave (
        input  wb_req, wb_id, wb_data,
        output wb_gnt,
        input  stk_req, stk_push, stk_pop,
        output stk_gnt,
        input  fe_req, fe_a, fe_b, fe_two,
        output fe_gnt, fe_done, op_a, op_b, busy,
        output rf_rd, rf_wn, rf_reg_id, rf_write_data,
        output rf_stack_en, rf_push_en, rf_pop_en,
        input  rf_read_data
    );

    modport master (
        output wb_req, wb_id, wb_data,
        input  wb_gnt,
        output stk_req, stk_push, stk_pop,
        input  stk_gnt,
        output fe_req, fe_a, fe_b, fe_two,
        input  fe_gnt, fe_done, op_a, op_b, busy,
        input  rf_rd, rf_wn, rf_reg_id, rf_write_data,
        input  rf_stack_en, rf_push_en, rf_pop_en,
        output rf_read_data
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Single-port sequencer in front of the 16x16 register file (r2 = SP).
// Arbitrates writeback > stack adjust > operand fetch, with a starvation
// override that forces a long-waiting fetch through. Every output is a
// register whose next value is computed alongside the next state, so each
// output level belongs to the state the FSM is entering.
module regfile_access_ctrl #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input logic                  clk,
    input logic                  reset,
    regfile_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_STACK    = 3'd2,
        S_FETCH_A  = 3'd3,
        S_FETCH_B  = 3'd4,
        S_CAP_LAST = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    // Registered outputs
    logic        wb_gnt_q, wb_gnt_d;
    logic        stk_gnt_q, stk_gnt_d;
    logic        fe_gnt_q, fe_gnt_d;
    logic        fe_done_q, fe_done_d;
    logic        busy_q, busy_d;
    logic        rf_rd_q, rf_rd_d;
    logic        rf_wn_q, rf_wn_d;
    logic [3:0]  rf_reg_id_q, rf_reg_id_d;
    logic [15:0] rf_write_data_q, rf_write_data_d;
    logic        rf_stack_en_q, rf_stack_en_d;
    logic        rf_push_en_q, rf_push_en_d;
    logic        rf_pop_en_q, rf_pop_en_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;

    // Fetch fields still needed after FETCH_A has issued the first read
    logic [3:0]  fe_b_q, fe_b_d;
    logic        fe_two_q, fe_two_d;

    // Arbitration decision, only meaningful in IDLE
    logic fe_force;
    logic wb_win;
    logic stk_win;
    logic fe_win;

    // Decide the IDLE winner: wb > stk > fe, unless a starved fetch is forced
    always_comb begin
        fe_force = bus.fe_req && (starve_q == CNT_W'(STARVE_MAX));
        wb_win   = bus.wb_req && !fe_force;
        stk_win  = bus.stk_req && !bus.wb_req && !fe_force;
        fe_win   = bus.fe_req && (fe_force || (!bus.wb_req && !bus.stk_req));
    end

    // Next state, next starvation count and next value of every output
    always_comb begin
        state_d         = state_q;
        starve_d        = starve_q;
        wb_gnt_d        = 1'b0;
        stk_gnt_d       = 1'b0;
        fe_gnt_d        = 1'b0;
        fe_done_d       = 1'b0;
        rf_rd_d         = 1'b0;
        rf_wn_d         = 1'b0;
        rf_reg_id_d     = 4'd0;
        rf_write_data_d = 16'd0;
        rf_stack_en_d   = 1'b0;
        rf_push_en_d    = 1'b0;
        rf_pop_en_d     = 1'b0;
        op_a_d          = op_a_q;
        op_b_d          = op_b_q;
        fe_b_d          = fe_b_q;
        fe_two_d        = fe_two_q;

        case (state_q)
            S_IDLE: begin
                // A fetch that is waiting but loses this round ages by one;
                // winning clears its age.
                if (fe_win) begin
                    starve_d = '0;
                end else if (bus.fe_req && (starve_q != CNT_W'(STARVE_MAX))) begin
                    starve_d = starve_q + CNT_W'(1);
                end

                if (wb_win) begin
                    state_d         = S_WRITE;
                    wb_gnt_d        = 1'b1;
                    rf_wn_d         = 1'b1;
                    rf_reg_id_d     = bus.wb_id;
                    rf_write_data_d = bus.wb_data;
                end else if (stk_win) begin
                    state_d   = S_STACK;
                    stk_gnt_d = 1'b1;
                    // Conflicting or empty direction is granted as a no-op
                    if (bus.stk_push ^ bus.stk_pop) begin
                        rf_stack_en_d = 1'b1;
                        rf_push_en_d  = bus.stk_push;
                        rf_pop_en_d   = bus.stk_pop;
                    end
                end else if (fe_win) begin
                    state_d     = S_FETCH_A;
                    fe_gnt_d    = 1'b1;
                    rf_rd_d     = 1'b1;
                    rf_reg_id_d = bus.fe_a;
                    fe_b_d      = bus.fe_b;
                    fe_two_d    = bus.fe_two;
                end
            end

            S_WRITE: begin
                state_d = S_IDLE;
            end

            S_STACK: begin
                state_d = S_IDLE;
            end

            S_FETCH_A: begin
                // The first read is on the port now; issue the second if needed
                if (fe_two_q) begin
                    state_d     = S_FETCH_B;
                    rf_rd_d     = 1'b1;
                    rf_reg_id_d = fe_b_q;
                end else begin
                    state_d = S_CAP_LAST;
                end
            end

            S_FETCH_B: begin
                // Read data for fe_a arrives while fe_b is being read
                op_a_d  = bus.rf_read_data;
                state_d = S_CAP_LAST;
            end

            S_CAP_LAST: begin
                if (fe_two_q) begin
                    op_b_d = bus.rf_read_data;
                end else begin
                    op_a_d = bus.rf_read_data;
                    op_b_d = 16'd0;
                end
                fe_done_d = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, starvation counter and outputs; reset clears all of them
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            starve_q        <= '0;
            wb_gnt_q        <= 1'b0;
            stk_gnt_q       <= 1'b0;
            fe_gnt_q        <= 1'b0;
            fe_done_q       <= 1'b0;
            busy_q          <= 1'b0;
            rf_rd_q         <= 1'b0;
            rf_wn_q         <= 1'b0;
            rf_reg_id_q     <= 4'd0;
            rf_write_data_q <= 16'd0;
            rf_stack_en_q   <= 1'b0;
            rf_push_en_q    <= 1'b0;
            rf_pop_en_q     <= 1'b0;
            op_a_q          <= 16'd0;
            op_b_q          <= 16'd0;
        end else begin
            state_q         <= state_d;
            starve_q        <= starve_d;
            wb_gnt_q        <= wb_gnt_d;
            stk_gnt_q       <= stk_gnt_d;
            fe_gnt_q        <= fe_gnt_d;
            fe_done_q       <= fe_done_d;
            busy_q          <= busy_d;
            rf_rd_q         <= rf_rd_d;
            rf_wn_q         <= rf_wn_d;
            rf_reg_id_q     <= rf_reg_id_d;
            rf_write_data_q <= rf_write_data_d;
            rf_stack_en_q   <= rf_stack_en_d;
            rf_push_en_q    <= rf_push_en_d;
            rf_pop_en_q     <= rf_pop_en_d;
            op_a_q          <= op_a_d;
            op_b_q          <= op_b_d;
        end
    end

    // Latched fetch fields are pure data and are only read after a grant
    always_ff @(posedge clk) begin
        fe_b_q   <= fe_b_d;
        fe_two_q <= fe_two_d;
    end

    assign bus.wb_gnt        = wb_gnt_q;
    assign bus.stk_gnt       = stk_gnt_q;
    assign bus.fe_gnt        = fe_gnt_q;
    assign bus.fe_done       = fe_done_q;
    assign bus.busy          = busy_q;
    assign bus.rf_rd         = rf_rd_q;
    assign bus.rf_wn         = rf_wn_q;
    assign bus.rf_reg_id     = rf_reg_id_q;
    assign bus.rf_write_data = rf_write_data_q;
    assign bus.rf_stack_en   = rf_stack_en_q;
    assign bus.rf_push_en    = rf_push_en_q;
    assign bus.rf_pop_en     = rf_pop_en_q;
    assign bus.op_a          = op_a_q;
    assign bus.op_b          = op_b_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file, request drivers
// and a fetch scoreboard popped on every fe_done.
module tb_regfile_access_ctrl;

    localparam int STARVE_MAX = 4;
    localparam int TMO        = 60;

    logic clk = 1'b0;
    logic reset;

    regfile_access_ctrl_if bus();

    regfile_access_ctrl #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural 16x16 register file with one-cycle read latency
    logic [15:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 16'd0;

    always @(posedge clk) begin
        if (bus.rf_wn) mem[bus.rf_reg_id] <= bus.rf_write_data;
        if (bus.rf_stack_en && bus.rf_push_en) mem[2] <= mem[2] + 16'd1;
        else if (bus.rf_stack_en && bus.rf_pop_en) mem[2] <= mem[2] - 16'd1;
        bus.rf_read_data <= bus.rf_rd ? mem[bus.rf_reg_id] : 16'hDEAD;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        two;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   wb_cnt   = 0;
    int   done_cnt = 0;
    int   gnt_cyc  = 0;

    // Scoreboard side: every fe_done must match the oldest expected fetch
    always @(negedge clk) begin
        if (bus.wb_gnt) wb_cnt++;
        if (bus.fe_gnt) gnt_cyc = cyc;
        if (bus.fe_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("op_a", {16'd0, bus.op_a}, {16'd0, mon_e.a});
                chk("op_b", {16'd0, bus.op_b}, {16'd0, mon_e.b});
                chk("done_lat", cyc - gnt_cyc, mon_e.two ? 32'd3 : 32'd2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < TMO && !ok; i++) begin
            if (!bus.busy) ok = 1'b1;
            else tick();
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [15:0] d);
        bit seen = 1'b0;
        bus.wb_req  = 1'b1;
        bus.wb_id   = id;
        bus.wb_data = d;
        for (int i = 0; i < TMO && !seen; i++) begin
            tick();
            if (bus.wb_gnt) seen = 1'b1;
        end
        bus.wb_req = 1'b0;
        if (!seen) chk("wb_timeout", 32'd0, 32'd1);
        else chk("wr_lines", {11'd0, bus.rf_wn, bus.rf_reg_id, bus.rf_write_data},
                 {11'd0, 1'b1, id, d});
    endtask

    task automatic do_stack(input logic push, input logic pop);
        bit seen = 1'b0;
        bus.stk_req  = 1'b1;
        bus.stk_push = push;
        bus.stk_pop  = pop;
        for (int i = 0; i < TMO && !seen; i++) begin
            tick();
            if (bus.stk_gnt) seen = 1'b1;
        end
        bus.stk_req = 1'b0;
        if (!seen) chk("stk_timeout", 32'd0, 32'd1);
        else chk("stk_lines", {29'd0, bus.rf_stack_en, bus.rf_push_en, bus.rf_pop_en},
                 (push ^ pop) ? {29'd0, 1'b1, push, pop} : 32'd0);
    endtask

    task automatic fe_start(input logic [3:0] a, input logic [3:0] b, input logic two,
                            output int waited);
        bit seen = 1'b0;
        bus.fe_req = 1'b1;
        bus.fe_a   = a;
        bus.fe_b   = b;
        bus.fe_two = two;
        waited     = 0;
        for (int i = 0; i < TMO && !seen; i++) begin
            tick();
            waited++;
            if (bus.fe_gnt) seen = 1'b1;
        end
        bus.fe_req = 1'b0;
        if (!seen) chk("fe_gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic fe_wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < TMO && !seen; i++) begin
            tick();
            if (bus.fe_done) seen = 1'b1;
        end
        if (!seen) chk("fe_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic two);
        exp_t e;
        e.a   = a;
        e.b   = two ? b : 16'd0;
        e.two = two;
        sb.push_back(e);
    endtask

    task automatic do_fetch(input logic [3:0] a, input logic [3:0] b, input logic two,
                            input logic [15:0] ea, input logic [15:0] eb);
        int w;
        wait_idle();
        push_exp(ea, eb, two);
        fe_start(a, b, two, w);
        chk("fe_gnt_lat", w, 32'd1);
        fe_wait_done();
    endtask

    initial begin
        int w;
        int w0;
        int dc;
        int d0;
        bit seen;

        reset        = 1'b1;
        bus.wb_req   = 1'b0;
        bus.wb_id    = 4'd0;
        bus.wb_data  = 16'd0;
        bus.stk_req  = 1'b0;
        bus.stk_push = 1'b0;
        bus.stk_pop  = 1'b0;
        bus.fe_req   = 1'b0;
        bus.fe_a     = 4'd0;
        bus.fe_b     = 4'd0;
        bus.fe_two   = 1'b0;
        repeat (3) tick();
        chk("reset_outs", {10'd0, bus.busy, bus.rf_rd, bus.rf_wn, bus.rf_stack_en,
                           bus.rf_push_en, bus.rf_pop_en, bus.rf_reg_id, bus.wb_gnt,
                           bus.stk_gnt, bus.fe_gnt, bus.fe_done, 8'd0}, 32'd0);
        chk("reset_ops", {bus.op_a, bus.op_b}, 32'd0);
        reset = 1'b0;
        tick();

        // One-operand fetch after a write
        do_write(4'd5, 16'h1234);
        do_fetch(4'd5, 4'd0, 1'b0, 16'h1234, 16'h0);

        // Two-operand fetch
        do_write(4'd3, 16'h00AA);
        do_write(4'd7, 16'hBEEF);
        do_fetch(4'd3, 4'd7, 1'b1, 16'h00AA, 16'hBEEF);

        // Stack pointer adjust; one-operand fetch must also clear op_b
        do_write(4'd2, 16'h0010);
        do_stack(1'b1, 1'b0);
        do_stack(1'b1, 1'b0);
        do_stack(1'b0, 1'b1);
        do_fetch(4'd2, 4'd0, 1'b0, 16'h0011, 16'h0);
        do_stack(1'b1, 1'b1);
        do_stack(1'b0, 1'b0);
        do_fetch(4'd2, 4'd0, 1'b0, 16'h0011, 16'h0);

        // Starvation: wb held continuously alongside fe
        wait_idle();
        bus.wb_req  = 1'b1;
        bus.wb_id   = 4'd9;
        bus.wb_data = 16'h5555;
        w0 = wb_cnt;
        push_exp(16'h1234, 16'h0, 1'b0);
        fe_start(4'd5, 4'd0, 1'b0, w);
        chk("starve_wb_wins", wb_cnt - w0, STARVE_MAX);
        fe_wait_done();
        w0 = wb_cnt;
        push_exp(16'h5555, 16'h0, 1'b0);
        fe_start(4'd9, 4'd0, 1'b0, w);
        chk("starve_cleared", wb_cnt - w0, STARVE_MAX);
        fe_wait_done();
        seen = 1'b0;
        for (int i = 0; i < TMO && !seen; i++) begin
            tick();
            if (bus.wb_gnt) seen = 1'b1;
        end
        bus.wb_req = 1'b0;
        if (!seen) chk("wb_release_timeout", 32'd0, 32'd1);

        // Write arriving during FETCH_B waits; fetch sees the old value
        do_write(4'd4, 16'h0001);
        wait_idle();
        push_exp(16'h00AA, 16'h0001, 1'b1);
        fe_start(4'd3, 4'd4, 1'b1, w);
        tick();
        bus.wb_req  = 1'b1;
        bus.wb_id   = 4'd4;
        bus.wb_data = 16'h0002;
        fe_wait_done();
        dc   = cyc;
        seen = 1'b0;
        for (int i = 0; i < TMO && !seen; i++) begin
            tick();
            if (bus.wb_gnt) seen = 1'b1;
        end
        bus.wb_req = 1'b0;
        if (!seen) chk("wb_late_timeout", 32'd0, 32'd1);
        else chk("wb_after_done", cyc - dc, 32'd1);
        do_fetch(4'd4, 4'd0, 1'b0, 16'h0002, 16'h0);

        // Reset during FETCH_B abandons the fetch
        wait_idle();
        fe_start(4'd3, 4'd7, 1'b1, w);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_outs", {10'd0, bus.busy, bus.rf_rd, bus.rf_wn, bus.rf_stack_en,
                             bus.rf_push_en, bus.rf_pop_en, bus.rf_reg_id, bus.wb_gnt,
                             bus.stk_gnt, bus.fe_gnt, bus.fe_done, 8'd0}, 32'd0);
        chk("rst_mid_ops", {bus.op_a, bus.op_b}, 32'd0);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (10) tick();
        chk("no_done_after_rst", done_cnt - d0, 32'd0);

        // Recovery after reset
        do_fetch(4'd7, 4'd3, 1'b1, 16'hBEEF, 16'h00AA);
        repeat (3) tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
